// File: rtl/dsp_mac.sv
// dsp_mac: three-stage signed multiply / multiply-accumulate pipeline.
//   S1 registers the operands and qualifiers, S2 holds the full-precision
//   product, and S3 holds the accumulator and the reported result.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset; wins over ce
//   ce        - clock enable for every pipeline register
//   in_valid  - a/b/in_first/in_last qualify this cycle
//   in_first  - first sample of a frame (MODE=1)
//   in_last   - last sample of a frame (MODE=1)
//   a, b      - signed operands
//   out_valid - dout/ovf valid; consumers qualify it with ce
//   dout      - signed product (MODE=0) or frame sum (MODE=1)
//   ovf       - frame overflow flag (MODE=1), constant 0 in MODE=0
module dsp_mac #(
  parameter int unsigned A_W   = 9,
  parameter int unsigned B_W   = 33,
  parameter int unsigned ACC_W = 48,
  parameter int unsigned MODE  = 1,
  parameter int unsigned SAT   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] dout,
  output logic                    ovf
);

  localparam int unsigned P_W = A_W + B_W;
  // One guard bit above the accumulator exposes overflow of the add.
  localparam int unsigned S_W = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // S1 state
  logic signed [A_W-1:0]   a_q, a_d;
  logic signed [B_W-1:0]   b_q, b_d;
  logic                    v1_q, v1_d;
  logic                    first1_q, first1_d;
  logic                    last1_q, last1_d;

  // S2 state
  logic signed [P_W-1:0]   prod_q, prod_d;
  logic                    v2_q, v2_d;
  logic                    first2_q, first2_d;
  logic                    last2_q, last2_d;

  // S3 state
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_ovf_q, acc_ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] dout_q, dout_d;
  logic                    ovf_q, ovf_d;

  // Accumulate datapath
  logic signed [S_W-1:0]   prod_ext;
  logic signed [S_W-1:0]   base_ext;
  logic signed [S_W-1:0]   sum_full;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] frame_sum;

  // S1: operand capture; data only moves on accepted samples
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    v1_d     = v1_q;
    first1_d = first1_q;
    last1_d  = last1_q;
    if (ce) begin
      v1_d = in_valid;
      if (in_valid) begin
        a_d      = a;
        b_d      = b;
        first1_d = in_first;
        last1_d  = in_last;
      end
    end
  end

  // S2: exact signed product; P_W bits always hold it without loss
  always_comb begin
    prod_d   = prod_q;
    v2_d     = v2_q;
    first2_d = first2_q;
    last2_d  = last2_q;
    if (ce) begin
      v2_d = v1_q;
      if (v1_q) begin
        prod_d   = P_W'(a_q) * P_W'(b_q);
        first2_d = first1_q;
        last2_d  = last1_q;
      end
    end
  end

  // Sum at ACC_W+1 bits; a first sample starts from zero instead of acc_q
  always_comb begin
    prod_ext = S_W'(prod_q);
    if (first2_q) begin
      base_ext = '0;
    end else begin
      base_ext = S_W'(acc_q);
    end
    sum_full = base_ext + prod_ext;
    sum_ovf  = sum_full[S_W-1] ^ sum_full[S_W-2];
    if (sum_ovf && (SAT != 0)) begin
      frame_sum = sum_full[S_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      frame_sum = sum_full[ACC_W-1:0];
    end
  end

  // S3: accumulator, sticky overflow and result register
  always_comb begin
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (ce) begin
      out_valid_d = 1'b0;
      if (v2_q) begin
        if (MODE == 0) begin
          out_valid_d = 1'b1;
          dout_d      = prod_ext[ACC_W-1:0];
          ovf_d       = 1'b0;
        end else begin
          acc_d     = frame_sum;
          acc_ovf_d = (first2_q ? 1'b0 : acc_ovf_q) | sum_ovf;
          if (last2_q) begin
            out_valid_d = 1'b1;
            dout_d      = frame_sum;
            ovf_d       = acc_ovf_d;
          end
        end
      end
    end
  end

  // Pipeline registers; reset overrides ce and drops in-flight samples
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      first1_q    <= 1'b0;
      last1_q     <= 1'b0;
      prod_q      <= '0;
      v2_q        <= 1'b0;
      first2_q    <= 1'b0;
      last2_q     <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      first1_q    <= first1_d;
      last1_q     <= last1_d;
      prod_q      <= prod_d;
      v2_q        <= v2_d;
      first2_q    <= first2_d;
      last2_q     <= last2_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac.sv
// tb_dsp_mac: scoreboard bench for dsp_mac. Four instances share one
// stimulus stream: MAC 48-bit saturating (0), multiply-only (1),
// MAC 42-bit saturating (2), MAC 42-bit wrapping (3).
module tb_dsp_mac;

  typedef logic signed [63:0] s64_t;
  typedef struct {
    s64_t   dout;
    logic   ovf;
    longint stamp;
  } exp_t;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last;
  logic signed [8:0]  a;
  logic signed [32:0] b;

  logic ov0, ov1, ov2, ov3;
  logic ovf0, ovf1, ovf2, ovf3;
  logic signed [47:0] dout0, dout1;
  logic signed [41:0] dout2, dout3;

  always #5 clk = ~clk;

  dsp_mac u_mac (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov0), .dout(dout0), .ovf(ovf0));

  dsp_mac #(.MODE(0)) u_mul (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov1), .dout(dout1), .ovf(ovf1));

  dsp_mac #(.ACC_W(42), .SAT(1)) u_sat42 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov2), .dout(dout2), .ovf(ovf2));

  dsp_mac #(.ACC_W(42), .SAT(0)) u_wrap42 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov3), .dout(dout3), .ovf(ovf3));

  int     checks = 0;
  int     errors = 0;
  int     pulses[4];
  s64_t   last_dout[4];
  logic   last_ovf[4];
  int     hold_cnt = 0;
  longint en_cnt = 0;
  longint acc_m[4];
  logic   ovf_m[4];
  exp_t   q0[$], q1[$], q2[$], q3[$];

  function automatic void push_exp(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic bit pop_exp(input int k, output exp_t e);
    bit ok = 1'b0;
    e.dout = '0; e.ovf = 1'b0; e.stamp = 0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Reference model: integer arithmetic on 64-bit values, range-checked per width
  function automatic void model_accept();
    longint p, s, lo, hi, span;
    logic o;
    int w;
    exp_t e;
    p = longint'(a) * longint'(b);
    for (int k = 0; k < 4; k++) begin
      e.stamp = en_cnt;
      if (k == 1) begin
        e.dout = s64_t'(p); e.ovf = 1'b0;
        push_exp(k, e);
      end else begin
        w    = (k >= 2) ? 42 : 48;
        span = 64'sd1 <<< w;
        hi   = (span >>> 1) - 1;
        lo   = -(span >>> 1);
        s    = in_first ? p : acc_m[k] + p;
        o    = in_first ? 1'b0 : ovf_m[k];
        if (s > hi || s < lo) begin
          o = 1'b1;
          if (k != 3) begin
            s = (s > hi) ? hi : lo;
          end else begin
            s = s & (span - 1);
            if (s > hi) s = s - span;
          end
        end
        acc_m[k] = s;
        ovf_m[k] = o;
        if (in_last) begin
          e.dout = s64_t'(s); e.ovf = o;
          push_exp(k, e);
        end
      end
    end
  endfunction

  // Model update on each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int k = 0; k < 4; k++) begin acc_m[k] = 0; ovf_m[k] = 1'b0; end
      end else if (ce) begin
        en_cnt++;
        if (in_valid) model_accept();
      end
    end
  end

  // Output monitor on the falling edge
  initial begin
    logic ov_s[4];
    s64_t dl[4];
    logic ol[4];
    logic prev_hold[4];
    s64_t prev_dout[4];
    exp_t e;
    for (int k = 0; k < 4; k++) begin prev_hold[k] = 1'b0; prev_dout[k] = '0; end
    forever begin
      @(negedge clk);
      ov_s = '{ov0, ov1, ov2, ov3};
      ol   = '{ovf0, ovf1, ovf2, ovf3};
      dl[0] = s64_t'(dout0); dl[1] = s64_t'(dout1);
      dl[2] = s64_t'(dout2); dl[3] = s64_t'(dout3);
      for (int k = 0; k < 4; k++) begin
        if (prev_hold[k]) begin
          checks++;
          hold_cnt++;
          if (ov_s[k] !== 1'b1 || dl[k] !== prev_dout[k]) begin
            errors++;
            $display("FAIL hold inst%0d out_valid=%b dout=%0d want out_valid=1 dout=%0d",
                     k, ov_s[k], dl[k], prev_dout[k]);
          end
        end
        if (reset === 1'b0 && ce === 1'b1 && ov_s[k] === 1'b1) begin
          pulses[k]++;
          last_dout[k] = dl[k];
          last_ovf[k]  = ol[k];
          checks++;
          if (!pop_exp(k, e)) begin
            errors++;
            $display("FAIL sb_unexpected inst%0d dout=%0d ovf=%b want no output", k, dl[k], ol[k]);
          end else if (dl[k] !== e.dout || ol[k] !== e.ovf || en_cnt != e.stamp + 2) begin
            errors++;
            $display("FAIL sb_result inst%0d dout=%0d ovf=%b lat=%0d want dout=%0d ovf=%b lat=2",
                     k, dl[k], ol[k], en_cnt - e.stamp, e.dout, e.ovf);
          end
        end
        prev_hold[k] = (reset === 1'b0) && (ce === 1'b0) && (ov_s[k] === 1'b1);
        prev_dout[k] = dl[k];
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge
  task automatic cyc(input logic v, input logic f, input logic l,
                     input logic signed [8:0] av, input logic signed [32:0] bv,
                     input logic cev);
    in_valid = v; in_first = f; in_last = l; a = av; b = bv; ce = cev;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with garbage data and qualifiers that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 9'($urandom), $signed({1'($urandom), 32'($urandom)}), 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    checks++;
    if ({ov0, ov1, ov2, ov3} !== 4'b0 || {ovf0, ovf1, ovf2, ovf3} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags out_valid=%b ovf=%b want 0000/0000",
               {ov0, ov1, ov2, ov3}, {ovf0, ovf1, ovf2, ovf3});
    end
    checks++;
    if (dout0 !== 48'sd0 || dout1 !== 48'sd0 || dout2 !== 42'sd0 || dout3 !== 42'sd0) begin
      errors++;
      $display("FAIL reset_dout got %0d %0d %0d %0d want 0", dout0, dout1, dout2, dout3);
    end
  endtask

  task automatic test_mult_only();
    int p1 = pulses[1];
    cyc(1'b1, 1'b0, 1'b0, -9'sd256, 33'sd4294967295, 1'b1);
    idle(5);
    checks++;
    if (pulses[1] != p1 + 1 || last_dout[1] !== -64'sd1099511627520 || last_ovf[1] !== 1'b0) begin
      errors++;
      $display("FAIL mult_only pulses=%0d dout=%0d ovf=%b want pulses=%0d dout=-1099511627520 ovf=0",
               pulses[1] - p1, last_dout[1], last_ovf[1], 1);
    end
  endtask

  task automatic send_frame_327(input logic toggle_ce);
    logic signed [32:0] bs[4];
    bs = '{33'sd5, -33'sd7, 33'sd11, 33'sd100};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'(i == 0), 1'(i == 3), 9'sd3, bs[i], 1'b1);
      if (toggle_ce) cyc(1'b1, 1'b1, 1'b1, 9'($urandom), 33'sd77, 1'b0);
    end
  endtask

  task automatic test_frame();
    int p0 = pulses[0];
    send_frame_327(1'b0);
    idle(5);
    checks++;
    if (pulses[0] != p0 + 1 || last_dout[0] !== 64'sd327 || last_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL frame_sum pulses=%0d dout=%0d ovf=%b want pulses=1 dout=327 ovf=0",
               pulses[0] - p0, last_dout[0], last_ovf[0]);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'(i == 0), 1'(i == 3), 9'sd255, 33'sd4294967295, 1'b1);
    idle(5);
    checks++;
    if (last_dout[2] !== 64'sd2199023255551 || last_ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp dout=%0d ovf=%b want dout=2199023255551 ovf=1", last_dout[2], last_ovf[2]);
    end
    checks++;
    if (last_dout[3] !== -64'sd17179870204 || last_ovf[3] !== 1'b1) begin
      errors++;
      $display("FAIL wrap dout=%0d ovf=%b want dout=-17179870204 ovf=1", last_dout[3], last_ovf[3]);
    end
    checks++;
    if (last_dout[0] !== 64'sd4380866640900 || last_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL wide_no_ovf dout=%0d ovf=%b want dout=4380866640900 ovf=0", last_dout[0], last_ovf[0]);
    end
    cyc(1'b1, 1'b1, 1'b1, 9'sd1, 33'sd1, 1'b1);
    idle(5);
    checks++;
    if (last_dout[2] !== 64'sd1 || last_ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL single_frame dout=%0d ovf=%b want dout=1 ovf=0", last_dout[2], last_ovf[2]);
    end
  endtask

  task automatic test_ce_toggle();
    int p0 = pulses[0];
    int h0 = hold_cnt;
    send_frame_327(1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b1, 9'($urandom), 33'sd9, 1'(i % 2));
    idle(2);
    checks++;
    if (pulses[0] != p0 + 1 || last_dout[0] !== 64'sd327) begin
      errors++;
      $display("FAIL ce_frame pulses=%0d dout=%0d want pulses=1 dout=327", pulses[0] - p0, last_dout[0]);
    end
    checks++;
    if (hold_cnt <= h0) begin
      errors++;
      $display("FAIL ce_hold_seen holds=%0d want >0", hold_cnt - h0);
    end
  endtask

  task automatic test_reset_midframe();
    int p0;
    cyc(1'b1, 1'b1, 1'b0, 9'sd3, 33'sd5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 9'sd3, 33'sd5, 1'b1);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 9'sd3, 33'sd5, 1'b0);
    reset = 1'b0;
    checks++;
    if (dout0 !== 48'sd0 || ov0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ce0 dout=%0d out_valid=%b ovf=%b want 0/0/0", dout0, ov0, ovf0);
    end
    p0 = pulses[0];
    cyc(1'b1, 1'b1, 1'b0, 9'sd2, 33'sd2, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 9'sd2, 33'sd2, 1'b1);
    idle(6);
    checks++;
    if (pulses[0] != p0 + 1 || last_dout[0] !== 64'sd8) begin
      errors++;
      $display("FAIL reset_midframe pulses=%0d dout=%0d want pulses=1 dout=8", pulses[0] - p0, last_dout[0]);
    end
  endtask

  task automatic test_accumulate_after_reset();
    int p0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    p0 = pulses[0];
    cyc(1'b1, 1'b0, 1'b1, 9'sd3, 33'sd4, 1'b1);
    idle(4);
    checks++;
    if (last_dout[0] !== 64'sd12) begin
      errors++;
      $display("FAIL acc_from_zero dout=%0d want 12", last_dout[0]);
    end
    cyc(1'b1, 1'b0, 1'b1, 9'sd1, 33'sd1, 1'b1);
    idle(5);
    checks++;
    if (pulses[0] != p0 + 2 || last_dout[0] !== 64'sd13) begin
      errors++;
      $display("FAIL acc_after_frame pulses=%0d dout=%0d want pulses=2 dout=13", pulses[0] - p0, last_dout[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
          9'($urandom), $signed({1'($urandom), 32'($urandom)}), 1'($urandom_range(0, 3) != 0));
    idle(6);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_size(k) != 0) begin
        errors++;
        $display("FAIL drain inst%0d pending=%0d want 0", k, q_size(k));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      pulses[k] = 0; last_dout[k] = '0; last_ovf[k] = 1'b0; acc_m[k] = 0; ovf_m[k] = 1'b0;
    end
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a = '0; b = '0;
    test_reset();
    test_mult_only();
    test_frame();
    test_overflow();
    test_ce_toggle();
    test_reset_midframe();
    test_accumulate_after_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
